// File: rtl/operand_entry_if.sv
// Operand-entry bundle: raw board switches/buttons in, captured ALU operands out.
// The master side is the operand collector, the slave side is the board/consumer.
interface operand_entry_if;
    logic [7:0]  ins;
    logic [2:0]  sw;
    logic        btn_enter;
    logic        btn_clear;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [2:0]  op;
    logic        valid;
    logic [1:0]  state;

    modport master (
        input  ins, sw, btn_enter, btn_clear,
        output num1, num2, op, valid, state
    );

    modport slave (
        output ins, sw, btn_enter, btn_clear,
        input  num1, num2, op, valid, state
    );
endinterface

// File: rtl/operand_entry.sv
// Collects two 8-bit operands and a 3-bit opcode from switches using debounced
// enter/clear buttons, and presents them as registered outputs with a valid strobe.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    operand_entry_if.master        bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StA    = 2'b00,
        StB    = 2'b01,
        StDone = 2'b10
    } state_t;

    // Button vectors: bit 0 = enter, bit 1 = clear.
    logic [7:0]            r_ins_s1, r_ins_s2;
    logic [2:0]            r_sw_s1, r_sw_s2;
    logic [1:0]            r_btn_s1, r_btn_s2;
    logic [1:0][CNT_W-1:0] r_cnt;
    logic [1:0]            r_deb, r_deb_d;
    logic [1:0]            w_press;

    logic [7:0]            r_num1, r_num2;
    logic [2:0]            r_op;
    logic                  r_valid;
    state_t                r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ins_s1 <= '0;
            r_ins_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_cnt    <= '0;
            r_deb    <= '0;
            r_deb_d  <= '0;
        end else begin
            r_ins_s1 <= bus.ins;
            r_ins_s2 <= r_ins_s1;
            r_sw_s1  <= bus.sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= {bus.btn_clear, bus.btn_enter};
            r_btn_s2 <= r_btn_s1;
            // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CntMax) begin
                    r_deb[i] <= r_btn_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_deb_d <= r_deb;
        end
    end

    assign w_press = r_deb & ~r_deb_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num1  <= '0;
            r_num2  <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
            r_state <= StA;
        end else begin
            r_valid <= 1'b0;
            if (w_press[1]) begin
                r_num1  <= '0;
                r_num2  <= '0;
                r_op    <= '0;
                r_state <= StA;
            end else begin
                case (r_state)
                    StA: begin
                        if (w_press[0]) begin
                            r_num1  <= r_ins_s2;
                            r_state <= StB;
                        end
                    end
                    StB: begin
                        if (w_press[0]) begin
                            r_num2  <= r_ins_s2;
                            r_op    <= r_sw_s2;
                            r_valid <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                    StDone: begin
                        if (w_press[0]) begin
                            r_num1  <= r_ins_s2;
                            r_state <= StB;
                        end
                    end
                    default: r_state <= StA;
                endcase
            end
        end
    end

    assign bus.num1  = {24'b0, r_num1};
    assign bus.num2  = {24'b0, r_num2};
    assign bus.op    = r_op;
    assign bus.valid = r_valid;
    assign bus.state = r_state;

endmodule
